// File: rtl/clkdiv_mon_pkg.sv
// Shared types and defaults for the divided-clock monitor.
package clkdiv_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } clkdiv_mon_state_t;

    localparam int HALF_PERIOD_DEF = 8;
    localparam int TOL_DEF         = 0;
    localparam int LOCK_CNT_DEF    = 4;
    localparam int CNT_W_DEF       = 8;
    localparam int ERR_CNT_W       = 8;

    // Saturating increment for the error counter.
    function automatic logic [ERR_CNT_W-1:0] err_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/clkdiv_mon_if.sv
// Divided-clock interface: the divider drives div_in, the monitor returns status.
interface clkdiv_mon_if
    import clkdiv_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic                 div_in;
    logic                 rise_pulse;
    logic                 fall_pulse;
    logic [CNT_W-1:0]     half_period;
    logic                 locked;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output div_in,
        input  rise_pulse, fall_pulse, half_period, locked, err, err_cnt
    );

    modport slave (
        input  div_in,
        output rise_pulse, fall_pulse, half_period, locked, err, err_cnt
    );
endinterface

// File: rtl/clkdiv_edge_det.sv
// Edge detector for the divided clock: optional 2-flop synchronizer, sample
// register, div_q priming after reset and registered rise/fall strobes.
// Optional feature macro: CLKDIV_MON_SYNC_EN (adds the synchronizer).
module clkdiv_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic div_in,
    output logic edge_det,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic smp_in;

`ifdef CLKDIV_MON_SYNC_EN
    // div_q only holds real input data 4 cycles after reset release once the
    // synchronizer (reset to 0) has flushed through the sample register.
    localparam logic [2:0] PRIME_CYC = 3'd4;
    logic [1:0] sync_q;

    // Two-flop synchronizer for an asynchronous div_in.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], div_in};
    end
    assign smp_in = sync_q[1];
`else
    localparam logic [2:0] PRIME_CYC = 3'd1;
    assign smp_in = div_in;
`endif

    logic       smp_q;
    logic       div_q;
    logic [2:0] prime_cnt;
    logic       primed;

    assign primed   = (prime_cnt == PRIME_CYC);
    assign edge_det = primed && (smp_q != div_q);

    // Sample and previous-sample registers; div_q keeps following the sample
    // during reset so it is already primed when detection is enabled.
    always_ff @(posedge clk) begin
        smp_q <= smp_in;
        div_q <= smp_q;
    end

    // Suppress detection until div_q has been primed with valid data.
    always_ff @(posedge clk) begin
        if (rst)          prime_cnt <= 3'd0;
        else if (!primed) prime_cnt <= prime_cnt + 3'd1;
    end

    // Registered one-cycle edge strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= edge_det &  smp_q;
            fall_pulse <= edge_det & ~smp_q;
        end
    end

endmodule

// File: rtl/clkdiv_monitor.sv
// Divided-clock monitor: measures half-periods of div_in in clk cycles,
// locks after LOCK_CNT good measurements and flags deviations while locked.
// Optional feature macro: CLKDIV_MON_SYNC_EN (input synchronizer in clkdiv_edge_det).
module clkdiv_monitor
    import clkdiv_mon_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int TOL         = TOL_DEF,
    parameter int LOCK_CNT    = LOCK_CNT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    clkdiv_mon_if.slave  mon
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam int LO   = HALF_PERIOD - TOL;
    localparam int HI   = HALF_PERIOD + TOL;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                 edge_det;
    logic                 rise_pulse;
    logic                 fall_pulse;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     elapsed;
    logic                 good;
    logic                 timeout;
    clkdiv_mon_state_t    state;
    logic [GC_W-1:0]      good_cnt;
    logic [CNT_W-1:0]     half_period;
    logic                 locked;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    clkdiv_edge_det u_edge (
        .clk        (clk),
        .rst        (rst),
        .div_in     (mon.div_in),
        .edge_det   (edge_det),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // Elapsed cycles including the edge cycle itself, saturating.
    assign elapsed = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign good    = (int'(elapsed) >= LO) && (int'(elapsed) <= HI);
    // Fires once per stall: the counter moves past HI+1 on the next cycle.
    assign timeout = !edge_det && (int'(elapsed) == HI + 1);

    // Cycle counter since the last edge, saturating.
    always_ff @(posedge clk) begin
        if (rst)                 cnt <= '0;
        else if (edge_det)       cnt <= '0;
        else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end

    // Lock FSM with registered locked/err/half_period; an edge outranks timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            good_cnt    <= '0;
            half_period <= '0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    // First edge only starts acquisition; its period is unknown.
                    if (edge_det) begin
                        state    <= ACQ;
                        good_cnt <= '0;
                    end
                end
                ACQ: begin
                    if (edge_det) begin
                        half_period <= elapsed;
                        if (good) begin
                            good_cnt <= good_cnt + 1'b1;
                            if (good_cnt == GC_W'(LOCK_CNT - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end else if (timeout) begin
                        good_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (edge_det) half_period <= elapsed;
                    if ((edge_det && !good) || timeout) begin
                        err      <= 1'b1;
                        locked   <= 1'b0;
                        state    <= ACQ;
                        good_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    good_cnt <= '0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating error count, one cycle behind err.
    always_ff @(posedge clk) begin
        if (rst)      err_cnt <= '0;
        else if (err) err_cnt <= err_inc(err_cnt);
    end

    assign mon.rise_pulse  = rise_pulse;
    assign mon.fall_pulse  = fall_pulse;
    assign mon.half_period = half_period;
    assign mon.locked      = locked;
    assign mon.err         = err;
    assign mon.err_cnt     = err_cnt;

endmodule
